// File: rtl/mem_bus_controller.sv
// CPU-side bus controller. It decodes each access to the status bank, the internal
// sync-read RAM or the external port, and sequences it through one handshake FSM.
module mem_bus_controller #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned INT_MEM_BYTES = 32'h100000,
   parameter int unsigned STATUS_BASE   = 32'h2000,
   parameter int unsigned NUM_STATUS    = 4,
   parameter int unsigned EXT_TIMEOUT   = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [31:0]                      cpu_addr,
   input  logic [DATA_W-1:0]                cpu_wdata,
   input  logic                             cpu_read,
   input  logic                             cpu_write,
   output logic [DATA_W-1:0]                cpu_rdata,
   output logic                             cpu_ready,
   output logic                             cpu_bus_err,
   output logic [$clog2(INT_MEM_BYTES)-3:0] ram_addr,
   output logic [DATA_W-1:0]                ram_wdata,
   output logic                             ram_re,
   output logic                             ram_we,
   input  logic [DATA_W-1:0]                ram_rdata,
   output logic [31:0]                      ext_addr,
   output logic [DATA_W-1:0]                ext_wdata,
   output logic                             ext_read,
   output logic                             ext_write,
   input  logic [DATA_W-1:0]                ext_rdata,
   input  logic                             ext_ready,
   output logic [NUM_STATUS*DATA_W-1:0]     status_out,
   output logic                             busy
);

   localparam int unsigned RAM_MSB = $clog2(INT_MEM_BYTES) - 1;
   localparam int unsigned CNT_W   = $clog2(EXT_TIMEOUT + 1);
   localparam logic [31:0] STAT_LO = 32'(STATUS_BASE);
   localparam logic [31:0] STAT_HI = 32'(STATUS_BASE + 4 * NUM_STATUS);
   localparam logic [31:0] RAM_TOP = 32'(INT_MEM_BYTES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXT_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_STAT, S_RAM_REQ, S_RAM_RSP, S_EXT, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               wr_q, wr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [DATA_W-1:0]  status_q [NUM_STATUS];
   logic [DATA_W-1:0]  stat_rd;
   logic [3:0]         stat_idx;
   logic               stat_we;
   logic               in_stat;

   assign stat_idx = 4'((cpu_addr - STAT_LO) >> 2);
   assign in_stat  = (cpu_addr >= STAT_LO) && (cpu_addr < STAT_HI);

   always_comb begin
      stat_rd = '0;
      for (int i = 0; i < int'(NUM_STATUS); i++) begin
         if (stat_idx == 4'(i)) stat_rd = status_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      cnt_d   = '0;
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      stat_we = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_read || cpu_write) begin
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               wr_d    = cpu_write;
               if ((cpu_read && cpu_write) || (cpu_addr[1:0] != 2'b00)) begin
                  state_d = S_DONE;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
               end else if (in_stat) begin
                  // Status accesses complete at the accept edge; STAT is the response cycle.
                  state_d = S_STAT;
                  ready_d = 1'b1;
                  if (cpu_write) stat_we = 1'b1;
                  else           rdata_d = stat_rd;
               end else if (cpu_addr < RAM_TOP) begin
                  state_d = S_RAM_REQ;
               end else begin
                  state_d = S_EXT;
               end
            end
         end
         S_STAT:    state_d = S_DONE;
         S_RAM_REQ: begin
            state_d = S_RAM_RSP;
            ready_d = 1'b1;
         end
         S_RAM_RSP: begin
            state_d = S_DONE;
            if (!wr_q) rdata_d = ram_rdata;
         end
         S_EXT: begin
            cnt_d = cnt_q + 1'b1;
            if (ext_ready) begin
               state_d = S_DONE;
               ready_d = 1'b1;
               cnt_d   = '0;
               if (!wr_q) rdata_d = ext_rdata;
            end else if (cnt_d == CNT_MAX) begin
               state_d = S_DONE;
               ready_d = 1'b1;
               err_d   = 1'b1;
               cnt_d   = '0;
               if (!wr_q) rdata_d = '1;
            end
         end
         S_DONE: begin
            if (!cpu_read && !cpu_write) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_STATUS); i++) status_q[i] <= '0;
      end else if (stat_we) begin
         for (int i = 0; i < int'(NUM_STATUS); i++) begin
            if (stat_idx == 4'(i)) status_q[i] <= cpu_wdata;
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_STATUS); g++) begin : g_stat
      assign status_out[g*DATA_W +: DATA_W] = status_q[g];
   end

   // RAM data arrives during RAM_RSP, so it is forwarded while also being captured.
   assign cpu_rdata   = (state_q == S_RAM_RSP && !wr_q) ? ram_rdata : rdata_q;
   assign cpu_ready   = ready_q;
   assign cpu_bus_err = err_q;
   assign ram_addr    = addr_q[RAM_MSB:2];
   assign ram_wdata   = wdata_q;
   assign ram_re      = (state_q == S_RAM_REQ) && !wr_q;
   assign ram_we      = (state_q == S_RAM_REQ) && wr_q;
   assign ext_addr    = addr_q;
   assign ext_wdata   = wdata_q;
   assign ext_read    = (state_q == S_EXT) && !wr_q;
   assign ext_write   = (state_q == S_EXT) && wr_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_bus_controller.sv
// Randomised bench for mem_bus_controller: transaction-level reference model plus
// behavioural RAM and external-port responders.
module tb_mem_bus_controller;

   localparam int          DW  = 32;
   localparam int          NS  = 4;
   localparam int          TO  = 8;
   localparam int          RAW = 18;
   localparam logic [31:0] SB  = 32'h2000;
   localparam logic [31:0] IMB = 32'h100000;

   logic           clk = 1'b0;
   logic           rst;
   logic [31:0]    cpu_addr;
   logic [DW-1:0]  cpu_wdata;
   logic           cpu_read, cpu_write;
   logic [DW-1:0]  cpu_rdata;
   logic           cpu_ready, cpu_bus_err;
   logic [RAW-1:0] ram_addr;
   logic [DW-1:0]  ram_wdata;
   logic           ram_re, ram_we;
   logic [DW-1:0]  ram_rdata;
   logic [31:0]    ext_addr;
   logic [DW-1:0]  ext_wdata;
   logic           ext_read, ext_write;
   logic [DW-1:0]  ext_rdata;
   logic           ext_ready;
   logic [NS*DW-1:0] status_out;
   logic           busy;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ram_mem [int];
   logic [DW-1:0] m_ram [int];
   logic [DW-1:0] m_stat [NS];
   logic [DW-1:0] m_rdata;

   always #5 clk = ~clk;

   mem_bus_controller #(
      .DATA_W(DW), .INT_MEM_BYTES(IMB), .STATUS_BASE(SB),
      .NUM_STATUS(NS), .EXT_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_bus_err(cpu_bus_err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
      .ram_rdata(ram_rdata),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_read(ext_read), .ext_write(ext_write),
      .ext_rdata(ext_rdata), .ext_ready(ext_ready),
      .status_out(status_out), .busy(busy)
   );

   // Sync-read RAM: data appears one cycle after ram_re.
   always @(posedge clk) begin
      if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
      if (ram_re) ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : '0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int kind_of(input bit rd, input bit wr, input logic [31:0] a);
      if ((rd && wr) || a[1:0] != 2'b00) return 0;
      if (a >= SB && a < SB + 32'(4 * NS)) return 1;
      if (a < IMB) return 2;
      return 3;
   endfunction

   task automatic check_status();
      for (int i = 0; i < NS; i++) chk("status_word", status_out[i*DW +: DW], m_stat[i]);
   endtask

   // One CPU access; k = EXT cycle in which ext_ready rises; hold = cycles kept after ready.
   task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [DW-1:0] wd,
                         input int k, input logic [DW-1:0] xv, input int hold);
      int kind, lat, n, n_re, n_we, n_xr, n_xw, nx, first_x, ram_cyc, extra_r, extra_s, idx, wa;
      bit got, eerr, g_err;
      logic [DW-1:0] erd, g_rd, wd_seen;
      logic [31:0] xa_seen;
      logic [RAW-1:0] ra_seen;
      kind = kind_of(rd, wr, a);
      idx = int'((a - SB) >> 2);
      wa = int'(a[RAW+1:2]);
      erd = m_rdata; eerr = 1'b0; lat = 1;
      case (kind)
         0: eerr = 1'b1;
         1: if (rd) erd = m_stat[idx];
         2: begin lat = 2; if (rd) erd = m_ram.exists(wa) ? m_ram[wa] : '0; end
         default: begin
            if (k <= TO) begin lat = k + 1; if (rd) erd = xv; end
            else begin lat = TO + 1; eerr = 1'b1; if (rd) erd = '1; end
         end
      endcase
      n = 0; n_re = 0; n_we = 0; n_xr = 0; n_xw = 0; nx = 0; first_x = 0; ram_cyc = 0;
      extra_r = 0; extra_s = 0; got = 1'b0; g_err = 1'b0; g_rd = '0;
      wd_seen = '0; xa_seen = '0; ra_seen = '0;
      cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
      while (!got && n < 200) begin
         @(posedge clk); #1; n++;
         ext_ready = 1'b0; ext_rdata = ~xv;
         if (ram_re) begin n_re++; ram_cyc = n; ra_seen = ram_addr; end
         if (ram_we) begin n_we++; ram_cyc = n; ra_seen = ram_addr; wd_seen = ram_wdata; end
         if (ext_read || ext_write) begin
            nx++;
            if (ext_read) n_xr++; else n_xw++;
            if (first_x == 0) first_x = n;
            xa_seen = ext_addr; wd_seen = ext_wdata;
            if (nx == k) begin ext_ready = 1'b1; ext_rdata = xv; end
         end
         if (cpu_ready) begin got = 1'b1; g_err = cpu_bus_err; g_rd = cpu_rdata; end
      end
      chk("resp_seen", got, 1);
      chk("latency", n, lat);
      chk("bus_err", g_err, eerr);
      chk("rdata", g_rd, erd);
      case (kind)
         0, 1: chk("no_strobes", n_re + n_we + nx, 0);
         2: begin
            chk("ram_rd_pulses", n_re, rd ? 1 : 0);
            chk("ram_wr_pulses", n_we, wr ? 1 : 0);
            chk("ram_strobe_cycle", ram_cyc, 1);
            chk("ram_addr", ra_seen, a[RAW+1:2]);
            chk("ext_quiet", nx, 0);
            if (wr) chk("ram_wdata", wd_seen, wd);
         end
         default: begin
            chk("ext_cycles", nx, (k <= TO) ? k : TO);
            chk("ext_first", first_x, 1);
            chk("ext_dir", rd ? n_xw : n_xr, 0);
            chk("ext_addr", xa_seen, a);
            chk("ram_quiet", n_re + n_we, 0);
            if (wr) chk("ext_wdata", wd_seen, wd);
         end
      endcase
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (cpu_ready) extra_r++;
         if (ram_re || ram_we || ext_read || ext_write) extra_s++;
      end
      if (hold > 0) begin
         chk("hold_ready", extra_r, 0);
         chk("hold_strobes", extra_s, 0);
      end
      cpu_read = 1'b0; cpu_write = 1'b0; ext_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("idle_busy", busy, 0);
      chk("rdata_held", cpu_rdata, erd);
      if (kind == 1 && wr) m_stat[idx] = wd;
      if (kind == 2 && wr) m_ram[wa] = wd;
      m_rdata = erd;
      check_status();
   endtask

   initial begin
      logic [31:0] a;
      int sel;
      rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ext_ready = 1'b0; ext_rdata = '0;
      for (int i = 0; i < NS; i++) m_stat[i] = '0;
      m_rdata = '0;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_ready", cpu_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {ram_re, ram_we, ext_read, ext_write}, 0);
      chk("rst_rdata", cpu_rdata, 0);
      check_status();
      rst = 1'b0;

      access(0, 1, 32'h2004, 32'hDEADBEEF, 0, '0, 0);
      access(1, 0, 32'h2004, '0, 0, '0, 0);
      chk("status_w1", status_out[63:32], 32'hDEADBEEF);

      // Reset in the middle of an external read.
      cpu_read = 1'b1; cpu_addr = 32'h0030_0000;
      repeat (3) begin @(posedge clk); #1; end
      chk("t1_ext_read_pre", ext_read, 1);
      #2 rst = 1'b1;
      #1;
      chk("t1_ext_read_rst", ext_read, 0);
      chk("t1_busy_rst", busy, 0);
      chk("t1_ready_rst", cpu_ready, 0);
      chk("t1_status_rst", status_out, 0);
      cpu_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NS; i++) m_stat[i] = '0;
      m_rdata = '0;
      chk("t1_rdata_rst", cpu_rdata, 0);

      access(0, 1, 32'h8000, 32'h12345678, 0, '0, 0);
      access(1, 0, 32'h8000, '0, 0, '0, 0);
      access(1, 0, 32'h0020_0000, '0, 4, 32'hCAFE0001, 0);
      access(1, 0, 32'h0030_0000, '0, 1000, 32'h0BAD0BAD, 0);
      access(0, 1, 32'h8002, 32'h55AA55AA, 0, '0, 0);
      access(1, 1, 32'h8000, 32'h66666666, 0, '0, 3);
      access(1, 0, 32'h8000, '0, 0, '0, 1);

      access(0, 1, SB - 4, 32'hA0A0A0A0, 0, '0, 0);
      access(0, 1, SB + 16, 32'hB1B1B1B1, 0, '0, 0);
      access(0, 1, SB + 12, 32'hC2C2C2C2, 0, '0, 2);
      access(1, 0, SB - 4, '0, 0, '0, 0);
      access(1, 0, SB + 16, '0, 0, '0, 0);
      access(1, 0, SB + 12, '0, 0, '0, 0);
      access(0, 1, IMB - 4, 32'hD3D3D3D3, 0, '0, 0);
      access(1, 0, IMB - 4, '0, 0, '0, 0);
      access(1, 0, IMB, '0, 1, 32'h11112222, 0);
      access(0, 1, IMB + 8, 32'h33334444, TO, '0, 0);
      access(0, 1, IMB + 12, 32'h55556666, TO + 1, '0, 1);

      for (int t = 0; t < 60; t++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: begin
               a = SB + 32'($urandom_range(0, NS - 1) * 4);
               access(sel == 0, sel != 0, a, $urandom, 0, '0, $urandom_range(0, 2));
            end
            3, 4, 5: begin
               a = 32'($urandom_range(0, 63) * 4);
               access(sel == 3, sel != 3, a, $urandom, 0, '0, $urandom_range(0, 2));
            end
            6, 7: begin
               a = IMB + 32'($urandom_range(0, 255) * 4);
               access(sel == 6, sel != 6, a, $urandom, $urandom_range(1, TO + 3), $urandom,
                      $urandom_range(0, 2));
            end
            8: begin
               a = {$urandom_range(0, 32'h3FFFF) , 2'b00} | 32'($urandom_range(1, 3));
               access($urandom_range(0, 1) == 1, 1'b1, a, $urandom, 1, $urandom,
                      $urandom_range(0, 2));
            end
            default: begin
               a = 32'($urandom_range(0, 63) * 4);
               access(1'b1, 1'b1, a, $urandom, 1, $urandom, $urandom_range(0, 3));
            end
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
